servo_pwm_scheduler: RTL and testbench



---
 rtl/servo_pwm_scheduler.sv | 153 +++++++++++++++
 tb/tb_servo_pwm_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_scheduler.sv
// Time-multiplexed servo PWM: 1 us tick from clk, one frame per FRAME_US ticks, channels pulsed back-to-back.
// Outputs registered (wr_ready combinational); writes stall only in the frame-boundary cycle and apply at the next boundary.
module servo_pwm_scheduler #(
   parameter int TICK_DIV = 100,
   parameter int FRAME_US = 20000,
   parameter int MIN_US   = 1000,
   parameter int SPAN_US  = 1000,
   parameter int CHANNELS = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [$clog2(CHANNELS)-1:0] wr_ch,
   input  logic [9:0]                  wr_pos,
   output logic                        wr_err,
   output logic [CHANNELS-1:0]         servo_pwm,
   output logic                        frame_start,
   output logic [$clog2(CHANNELS)-1:0] active_ch,
   output logic                        busy
);
   localparam int CW = $clog2(CHANNELS);
   localparam int TW = $clog2(TICK_DIV);
   localparam int UW = $clog2(FRAME_US);

   localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [UW-1:0]       US_LAST   = UW'(FRAME_US - 1);
   localparam logic [9:0]          SPAN_V    = 10'(SPAN_US);
   localparam logic [9:0]          MID_V     = 10'(SPAN_US / 2);
   localparam logic [10:0]         MIN_V     = 11'(MIN_US);
   localparam logic [CW-1:0]       LAST_CH   = CW'(CHANNELS - 1);
   localparam logic [CHANNELS-1:0] PWM_ONE   = CHANNELS'(1);

   typedef enum logic {ST_DONE, ST_PULSE} state_e;

   state_e                state_q, state_d;
   logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [UW-1:0]         us_cnt_q, us_cnt_d;
   logic [CW-1:0]         ch_q, ch_d;
   logic [CW-1:0]         nxt_ch;
   logic [10:0]           width_q, width_d;
   logic [9:0]            shadow_q [CHANNELS];
   logic [9:0]            active_q [CHANNELS];
   logic [CHANNELS-1:0]   pwm_q, pwm_d;
   logic [CW-1:0]         active_ch_q, active_ch_d;
   logic                  busy_q, busy_d;
   logic                  frame_start_q;
   logic                  wr_err_q;
   logic                  tick;
   logic                  boundary;
   logic                  wr_acc;
   logic                  wr_bad;
   logic [9:0]            wr_pos_sat;

   assign tick       = (tick_cnt_q == TICK_LAST);
   assign boundary   = tick && (us_cnt_q == US_LAST);
   assign wr_ready   = !boundary;
   assign wr_acc     = wr_valid && !boundary;
   assign wr_bad     = (32'(wr_ch) >= 32'(CHANNELS));
   assign wr_pos_sat = (wr_pos > SPAN_V) ? SPAN_V : wr_pos;
   assign nxt_ch     = ch_q + CW'(1);

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
      us_cnt_d   = us_cnt_q;
      if (tick) begin
         us_cnt_d = (us_cnt_q == US_LAST) ? '0 : us_cnt_q + UW'(1);
      end
   end

   // Boundary wins over any in-flight pulse so a mis-parameterised frame still restarts cleanly.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      width_d = width_q;
      if (boundary) begin
         state_d = ST_PULSE;
         ch_d    = '0;
         width_d = MIN_V + 11'(shadow_q[0]);
      end else if (state_q == ST_PULSE && tick) begin
         if (width_q == 11'd1) begin
            if (ch_q == LAST_CH) begin
               state_d = ST_DONE;
            end else begin
               ch_d    = nxt_ch;
               width_d = MIN_V + 11'(active_q[nxt_ch]);
            end
         end else begin
            width_d = width_q - 11'd1;
         end
      end
   end

   always_comb begin
      pwm_d       = '0;
      busy_d      = 1'b0;
      active_ch_d = '0;
      if (state_d == ST_PULSE) begin
         pwm_d       = PWM_ONE << ch_d;
         busy_d      = 1'b1;
         active_ch_d = ch_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q    <= '0;
         us_cnt_q      <= US_LAST;
         state_q       <= ST_DONE;
         ch_q          <= '0;
         width_q       <= '0;
         pwm_q         <= '0;
         busy_q        <= 1'b0;
         active_ch_q   <= '0;
         frame_start_q <= 1'b0;
         wr_err_q      <= 1'b0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         us_cnt_q      <= us_cnt_d;
         state_q       <= state_d;
         ch_q          <= ch_d;
         width_q       <= width_d;
         pwm_q         <= pwm_d;
         busy_q        <= busy_d;
         active_ch_q   <= active_ch_d;
         frame_start_q <= boundary;
         wr_err_q      <= wr_acc && wr_bad;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= MID_V;
            active_q[i] <= MID_V;
         end
      end else begin
         if (wr_acc && !wr_bad) begin
            shadow_q[wr_ch] <= wr_pos_sat;
         end
         if (boundary) begin
            active_q <= shadow_q;
         end
      end
   end

   assign servo_pwm   = pwm_q;
   assign busy        = busy_q;
   assign active_ch   = active_ch_q;
   assign frame_start = frame_start_q;
   assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Scoreboarded bench for servo_pwm_scheduler: frame-level reference model predicts pulse trains and handshakes.
module tb_servo_pwm_scheduler;
   localparam int TD        = 4;
   localparam int FR        = 1000;
   localparam int MN        = 100;
   localparam int SP        = 100;
   localparam int NC        = 4;
   localparam int FRAME_CLK = TD * FR;

   typedef struct {
      int ch;
      int width;
      bit last;
   } pulse_t;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       wr_valid = 1'b0;
   logic [1:0] wr_ch    = 2'd0;
   logic [9:0] wr_pos   = 10'd0;
   logic       wr_ready, wr_err, frame_start, busy;
   logic [3:0] servo_pwm;
   logic [1:0] active_ch;

   logic       wr_valid3 = 1'b0;
   logic [1:0] wr_ch3    = 2'd0;
   logic [9:0] wr_pos3   = 10'd0;
   logic       wr_ready3, wr_err3, frame_start3, busy3;
   logic [2:0] servo_pwm3;
   logic [1:0] active_ch3;

   always #5 clk = ~clk;

   servo_pwm_scheduler #(
      .TICK_DIV(TD), .FRAME_US(FR), .MIN_US(MN), .SPAN_US(SP), .CHANNELS(NC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_ch(wr_ch), .wr_pos(wr_pos), .wr_err(wr_err), .servo_pwm(servo_pwm),
      .frame_start(frame_start), .active_ch(active_ch), .busy(busy)
   );

   servo_pwm_scheduler #(
      .TICK_DIV(TD), .FRAME_US(FR), .MIN_US(MN), .SPAN_US(SP), .CHANNELS(3)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
      .wr_ch(wr_ch3), .wr_pos(wr_pos3), .wr_err(wr_err3), .servo_pwm(servo_pwm3),
      .frame_start(frame_start3), .active_ch(active_ch3), .busy(busy3)
   );

   int     n_pass  = 0;
   int     n_total = 0;
   int     n       = 0;
   bit     acc_last = 1'b0;
   bit     exp_err  = 1'b0;
   int     shadow_m [NC];
   int     frame_w  [NC];
   int     frame_b  = -1;
   pulse_t exp_q [$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
   endtask

   // Edge e (counted from reset release) is a frame boundary when it closes tick 1, FR+1, 2FR+1, ...
   function automatic bit is_bnd(input int e);
      return (e >= TD) && (e % TD == 0) && (((e / TD) - 1) % FR == 0);
   endfunction

   function automatic int exp_ch(input int m);
      int off;
      int acc;
      if (frame_b < 0) return -1;
      off = m - frame_b;
      acc = 0;
      for (int c = 0; c < NC; c++) begin
         acc += frame_w[c];
         if (off < acc) return c;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      pulse_t p;
      if (!rst_n) begin
         n        = 0;
         acc_last = 1'b0;
         exp_err  = 1'b0;
         frame_b  = -1;
         exp_q.delete();
         for (int c = 0; c < NC; c++) begin
            shadow_m[c] = SP / 2;
            frame_w[c]  = 0;
         end
      end else begin
         n++;
         acc_last = wr_valid && !is_bnd(n);
         exp_err  = acc_last && (int'(wr_ch) >= NC);
         if (is_bnd(n)) begin
            frame_b = n;
            for (int c = 0; c < NC; c++) begin
               frame_w[c] = (MN + shadow_m[c]) * TD;
               p.ch    = c;
               p.width = frame_w[c];
               p.last  = (c == NC - 1);
               exp_q.push_back(p);
            end
         end
         if (acc_last && int'(wr_ch) < NC)
            shadow_m[wr_ch] = (int'(wr_pos) > SP) ? SP : int'(wr_pos);
      end
   end

   task automatic end_pulse(input int ch, input int len, input bit to_zero);
      pulse_t e;
      if (exp_q.size() == 0) begin
         chk("sb_underflow", exp_q.size(), 1);
         return;
      end
      e = exp_q.pop_front();
      chk("pulse_ch", ch, e.ch);
      chk("pulse_width", len, e.width);
      chk("pulse_handover", to_zero, e.last);
   endtask

   int cur_ch  = -1;
   int cur_len = 0;
   int last_fs = -1;

   always @(negedge clk) begin : monitor
      int e;
      int idx;
      if (!rst_n) begin
         cur_ch  = -1;
         cur_len = 0;
         last_fs = -1;
      end else begin
         e = exp_ch(n);
         chk("servo_pwm", servo_pwm, (e < 0) ? 0 : (1 << e));
         chk("busy", busy, e >= 0);
         chk("active_ch", active_ch, (e < 0) ? 0 : e);
         chk("frame_start", frame_start, is_bnd(n));
         chk("wr_ready", wr_ready, !is_bnd(n + 1));
         chk("wr_err", wr_err, exp_err);
         chk("onehot", $countones(servo_pwm) <= 1, 1);
         if (frame_start) begin
            if (last_fs >= 0) chk("frame_spacing", n - last_fs, FRAME_CLK);
            last_fs = n;
         end
         idx = -1;
         for (int c = 0; c < NC; c++) if (servo_pwm[c]) idx = c;
         if (idx != cur_ch) begin
            if (cur_ch >= 0) end_pulse(cur_ch, cur_len, idx < 0);
            cur_ch  = idx;
            cur_len = (idx >= 0) ? 1 : 0;
         end else if (idx >= 0) begin
            cur_len++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int ch, input int pos);
      wr_valid = 1'b1;
      wr_ch    = 2'(ch);
      wr_pos   = 10'(pos);
      for (int k = 0; k < 4; k++) begin
         step();
         if (acc_last) break;
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_bnd_next();
      for (int k = 0; k < FRAME_CLK + 2 * TD && !is_bnd(n + 1); k++) step();
   endtask

   task automatic wait_bnd_now();
      for (int k = 0; k < FRAME_CLK + 2 * TD && !is_bnd(n); k++) step();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_servo_pwm"}, servo_pwm, 0);
      chk({tag, "_frame_start"}, frame_start, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_active_ch"}, active_ch, 0);
      chk({tag, "_wr_err"}, wr_err, 0);
      chk({tag, "_wr_ready"}, wr_ready, 1);
      chk({tag, "_servo_pwm3"}, servo_pwm3, 0);
   endtask

   initial begin : stim
      int cnt3 [3];
      bit seen;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_checks("reset");
      #2 rst_n = 1'b1;

      // First frame runs on reset shadows; retarget three channels mid-frame.
      while (n < TD * (1 + FR / 2)) step();
      write(1, 0);
      write(2, SP);
      write(3, 1023);

      // Write presented in the boundary cycle stalls and lands one frame later.
      wait_bnd_next();
      write(1, 37);

      for (int k = 0; k < 30; k++) begin
         repeat ($urandom_range(0, 500)) step();
         write($urandom_range(0, NC - 1),
               ($urandom_range(0, 1) != 0) ? $urandom_range(0, SP + 3) : $urandom_range(0, 1023));
      end
      wait_bnd_next();
      write(0, $urandom_range(0, SP));

      // Out-of-range channel on the 3-channel instance: error pulse, no width change.
      wait_bnd_now();
      repeat (20) step();
      wr_valid3 = 1'b1;
      wr_ch3    = 2'd3;
      wr_pos3   = 10'd0;
      chk("err_wr_ready", wr_ready3, 1);
      step();
      chk("err_pulse", wr_err3, 1);
      wr_ch3  = 2'd2;
      wr_pos3 = 10'(SP);
      step();
      wr_valid3 = 1'b0;
      chk("err_clear_after_good_write", wr_err3, 0);
      step();
      chk("err_stays_low", wr_err3, 0);
      wait_bnd_now();
      for (int c = 0; c < 3; c++) cnt3[c] = 0;
      for (int k = 0; k < FRAME_CLK; k++) begin
         for (int c = 0; c < 3; c++) if (servo_pwm3[c]) cnt3[c]++;
         step();
      end
      chk("ch3_w0", cnt3[0], (MN + SP / 2) * TD);
      chk("ch3_w1", cnt3[1], (MN + SP / 2) * TD);
      chk("ch3_w2", cnt3[2], (MN + SP) * TD);

      // Reset in the middle of channel 2's pulse drops outputs without a clock edge.
      seen = 1'b0;
      for (int k = 0; k < 2 * FRAME_CLK && !seen; k++) begin
         step();
         seen = servo_pwm[2];
      end
      chk("wait_ch2_pulse", seen, 1);
      repeat ($urandom_range(1, 50)) step();
      #2 rst_n = 1'b0;
      #1;
      reset_checks("async_reset");
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      wait_bnd_now();
      repeat (3400) step();
      chk("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
